// File: rtl/tsc_pkg.sv
// tsc_pkg
// Shared definitions for the TSC / PFD synchronisation controller.
//   - CLKS_PER_SEC : default clock rate, used to size the trig/pps watchdog
//   - STATE_*      : encodings reported on state_o
//   - tsc_state_e  : controller state type, encoded with the STATE_* values
package tsc_pkg;

    localparam int CLKS_PER_SEC = 200000000;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_FIX_WAIT = 3'd1;
    localparam logic [2:0] STATE_SYNC     = 3'd2;
    localparam logic [2:0] STATE_SETTLE   = 3'd3;
    localparam logic [2:0] STATE_TRACK    = 3'd4;
    localparam logic [2:0] STATE_HOLDOVER = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = STATE_IDLE,
        ST_FIX_WAIT = STATE_FIX_WAIT,
        ST_SYNC     = STATE_SYNC,
        ST_SETTLE   = STATE_SETTLE,
        ST_TRACK    = STATE_TRACK,
        ST_HOLDOVER = STATE_HOLDOVER
    } tsc_state_e;

endpackage

// File: rtl/tsc_lock_det.sv
// tsc_lock_det
// Classifies each PFD phase sample and counts consecutive good / bad samples.
//   clk, rst    : clock, asynchronous active-high reset
//   trig        : sample strobe (pdiff is valid)
//   pdiff       : signed phase difference in clocks
//   clear       : holds both run counters at zero
//   lock_hit    : this sample completes a run of LOCK_COUNT good samples
//   unlock_hit  : this sample completes a run of UNLOCK_COUNT bad samples
module tsc_lock_det #(
    parameter int LOCK_THRESH   = 100,
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_THRESH = 1000,
    parameter int UNLOCK_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [31:0] pdiff,
    input  logic        clear,
    output logic        lock_hit,
    output logic        unlock_hit
);

    logic [31:0] abs_val;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic        is_good;
    logic        is_bad;

    // The most negative value has no positive twin; clamp it to the max.
    always_comb begin
        if (pdiff == 32'h8000_0000)
            abs_val = 32'h7FFF_FFFF;
        else if (pdiff[31])
            abs_val = -pdiff;
        else
            abs_val = pdiff;
    end

    assign is_good = (abs_val <= 32'(LOCK_THRESH));
    assign is_bad  = (abs_val >  32'(UNLOCK_THRESH));

    // Hits fire on the sample that completes the run, so the controller
    // reacts on the same edge that records that sample.
    assign lock_hit   = trig && !clear && is_good && (good_cnt >= 32'(LOCK_COUNT - 1));
    assign unlock_hit = trig && !clear && is_bad  && (bad_cnt  >= 32'(UNLOCK_COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (clear) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (trig) begin
            if (is_good) begin
                if (good_cnt < 32'(LOCK_COUNT))
                    good_cnt <= good_cnt + 32'd1;
                bad_cnt <= '0;
            end else if (is_bad) begin
                if (bad_cnt < 32'(UNLOCK_COUNT))
                    bad_cnt <= bad_cnt + 32'd1;
                good_cnt <= '0;
            end else begin
                good_cnt <= '0;
                bad_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/tsc_sync_ctrl.sv
// tsc_sync_ctrl
// Sequences GPS fix qualification, TSC alignment, PFD resync and lock tracking.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 0 forces IDLE and clears internal counters
//   sw_resync     : software realign request (SETTLE / TRACK only)
//   gps_3dfix_d   : synchronised GPS 3D fix level
//   gps_1pps_d    : single-cycle pps pulse
//   pll_trig      : single-cycle PFD result strobe
//   pfd_status    : PFD busy in its resync path
//   pdiff_1pps    : signed PFD phase difference
//   tsc_sync      : alignment qualifier to the datapath
//   pfd_resync    : single-cycle PFD resync request
//   locked        : phase lock indication
//   holdover      : fix lost while locked
//   state_o       : current state encoding
//   resync_cnt    : saturating realignment count
module tsc_sync_ctrl #(
    parameter int CLKS_PER_SEC  = tsc_pkg::CLKS_PER_SEC,
    parameter int FIX_SECS      = 4,
    parameter int SETTLE_TRIGS  = 2,
    parameter int LOCK_THRESH   = 100,
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_THRESH = 1000,
    parameter int UNLOCK_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sw_resync,
    input  logic        gps_3dfix_d,
    input  logic        gps_1pps_d,
    input  logic        pll_trig,
    input  logic        pfd_status,
    input  logic [31:0] pdiff_1pps,
    output logic        tsc_sync,
    output logic        pfd_resync,
    output logic        locked,
    output logic        holdover,
    output logic [2:0]  state_o,
    output logic [15:0] resync_cnt
);

    import tsc_pkg::*;

    localparam logic [31:0] WD_LIMIT = 32'(2 * CLKS_PER_SEC);

    tsc_state_e  state;
    logic [31:0] wd_cnt;
    logic [31:0] fix_cnt;
    logic [31:0] settle_cnt;
    logic        wd_expire;
    logic        det_clear;
    logic        lock_hit;
    logic        unlock_hit;

    // One counter serves both the SYNC pps timeout and the trig watchdog;
    // it is zeroed on every state entry and on every pll_trig.
    assign wd_expire = (wd_cnt >= WD_LIMIT - 32'd1);
    assign det_clear = (state != ST_TRACK) || !enable;
    assign state_o   = state;

    tsc_lock_det #(
        .LOCK_THRESH   (LOCK_THRESH),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_THRESH (UNLOCK_THRESH),
        .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_lock_det (
        .clk        (clk),
        .rst        (rst),
        .trig       (pll_trig),
        .pdiff      (pdiff_1pps),
        .clear      (det_clear),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wd_cnt     <= '0;
            fix_cnt    <= '0;
            settle_cnt <= '0;
            tsc_sync   <= 1'b0;
            pfd_resync <= 1'b0;
            locked     <= 1'b0;
            holdover   <= 1'b0;
            resync_cnt <= '0;
        end else begin
            pfd_resync <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                wd_cnt     <= '0;
                fix_cnt    <= '0;
                settle_cnt <= '0;
                tsc_sync   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tsc_sync <= 1'b0;
                        fix_cnt  <= '0;
                        if (gps_3dfix_d)
                            state <= ST_FIX_WAIT;
                    end

                    ST_FIX_WAIT: begin
                        if (!gps_3dfix_d) begin
                            state <= ST_IDLE;
                        end else if (gps_1pps_d) begin
                            fix_cnt <= fix_cnt + 32'd1;
                            if (fix_cnt == 32'(FIX_SECS - 1)) begin
                                state    <= ST_SYNC;
                                tsc_sync <= 1'b1;
                                wd_cnt   <= '0;
                            end
                        end
                    end

                    // tsc_sync is raised on entry so it is already high when
                    // the aligning pps arrives.
                    ST_SYNC: begin
                        if (!gps_3dfix_d) begin
                            state    <= ST_IDLE;
                            tsc_sync <= 1'b0;
                        end else if (gps_1pps_d) begin
                            state      <= ST_SETTLE;
                            tsc_sync   <= 1'b0;
                            pfd_resync <= 1'b1;
                            settle_cnt <= '0;
                            wd_cnt     <= '0;
                        end else if (wd_expire) begin
                            state    <= ST_IDLE;
                            tsc_sync <= 1'b0;
                        end else begin
                            wd_cnt <= wd_cnt + 32'd1;
                        end
                    end

                    // Branch order gives fix loss > watchdog > sw_resync > trig;
                    // unlock_hit is only ever set in TRACK.
                    ST_SETTLE, ST_TRACK: begin
                        if (!gps_3dfix_d) begin
                            if (state == ST_TRACK && locked) begin
                                state    <= ST_HOLDOVER;
                                holdover <= 1'b1;
                                locked   <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else if (wd_expire || sw_resync || unlock_hit) begin
                            state    <= ST_SYNC;
                            tsc_sync <= 1'b1;
                            locked   <= 1'b0;
                            wd_cnt   <= '0;
                            if (resync_cnt != 16'hFFFF)
                                resync_cnt <= resync_cnt + 16'd1;
                        end else begin
                            wd_cnt <= pll_trig ? 32'd0 : wd_cnt + 32'd1;
                            if (state == ST_SETTLE) begin
                                if (pll_trig && !pfd_status) begin
                                    settle_cnt <= settle_cnt + 32'd1;
                                    if (settle_cnt == 32'(SETTLE_TRIGS - 1))
                                        state <= ST_TRACK;
                                end
                            end else if (lock_hit) begin
                                locked <= 1'b1;
                            end
                        end
                    end

                    ST_HOLDOVER: begin
                        tsc_sync <= 1'b0;
                        if (gps_3dfix_d) begin
                            state    <= ST_FIX_WAIT;
                            holdover <= 1'b0;
                            fix_cnt  <= '0;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        tsc_sync <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
